// File: rtl/multivar_cond_pkg.sv
// Shared types for the multi-variable condition waiter: opcodes, response
// status codes, write-select constants and controller states.
package multivar_cond_pkg;

  typedef enum logic [2:0] {
    OP_A_GT_B   = 3'd0,
    OP_SUM_LT_C = 3'd1,
    OP_B_PEAK   = 3'd2,
    OP_A_EQ_C   = 3'd3,
    OP_ALWAYS   = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_MET     = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_BADOP   = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  function automatic logic op_is_valid(input logic [2:0] op);
    return op <= OP_ALWAYS;
  endfunction

endpackage

// File: rtl/multivar_cond_waiter_pred.sv
// Combinational predicate evaluator over three signed variables.
module multivar_cond_pred
  import multivar_cond_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic        [2:0]        op,
  output logic                     true,
  output logic                     op_valid
);

  logic signed [DATA_W:0] sum;
  logic signed [DATA_W:0] c_ext;

  always_comb begin
    // One extra bit keeps a+b exact, so large positive sums never look negative.
    sum      = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    c_ext    = {c[DATA_W-1], c};
    true     = 1'b0;
    op_valid = 1'b1;
    case (op)
      OP_A_GT_B:   true = a > b;
      OP_SUM_LT_C: true = sum < c_ext;
      OP_B_PEAK:   true = (a < b) && (b > c);
      OP_A_EQ_C:   true = a == c;
      OP_ALWAYS:   true = 1'b1;
      default:     op_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multivar_cond_waiter.sv
// Waits until a predicate over registered variables a/b/c holds, with an
// optional false-cycle timeout, then returns a held response.
module multivar_cond_waiter
  import multivar_cond_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [TO_W-1:0]   req_timeout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [TO_W-1:0]   rsp_cycles,
  output logic [DATA_W-1:0] var_a,
  output logic [DATA_W-1:0] var_b,
  output logic [DATA_W-1:0] var_c
);

  state_e          state_q, state_nx;
  status_e         st_q, st_nx;
  logic [2:0]      op_q, op_nx;
  logic [TO_W-1:0] to_q, to_nx;
  logic [TO_W-1:0] cnt_q, cnt_nx;
  logic [TO_W-1:0] cyc_q, cyc_nx;
  logic [TO_W:0]   cnt_plus;
  logic            pred_true;
  logic            pred_op_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_a <= '0;
      var_b <= '0;
      var_c <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        SEL_A:    var_a <= wr_data;
        SEL_B:    var_b <= wr_data;
        SEL_C:    var_c <= wr_data;
        SEL_NONE: ;
        default:  ;
      endcase
    end
  end

  multivar_cond_pred #(.DATA_W(DATA_W)) u_pred (
    .a        (var_a),
    .b        (var_b),
    .c        (var_c),
    .op       (op_q),
    .true     (pred_true),
    .op_valid (pred_op_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= ST_MET;
      op_q    <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_nx;
      st_q    <= st_nx;
      op_q    <= op_nx;
      to_q    <= to_nx;
      cnt_q   <= cnt_nx;
      cyc_q   <= cyc_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    st_nx    = st_q;
    op_nx    = op_q;
    to_nx    = to_q;
    cnt_nx   = cnt_q;
    cyc_nx   = cyc_q;
    cnt_plus = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_nx  = req_op;
          to_nx  = req_timeout;
          cnt_nx = '0;
          if (op_is_valid(req_op)) begin
            state_nx = S_WAIT;
          end else begin
            st_nx    = ST_BADOP;
            cyc_nx   = '0;
            state_nx = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!pred_op_valid) begin
          st_nx    = ST_BADOP;
          cyc_nx   = '0;
          state_nx = S_RESP;
        end else if (pred_true) begin
          st_nx    = ST_MET;
          cyc_nx   = cnt_q;
          state_nx = S_RESP;
        end else if ((to_q != '0) && (cnt_plus == {1'b0, to_q})) begin
          // Timeout is checked only on a false cycle, so a true predicate wins.
          st_nx    = ST_TIMEOUT;
          cyc_nx   = to_q;
          cnt_nx   = to_q;
          state_nx = S_RESP;
        end else if (!cnt_plus[TO_W]) begin
          cnt_nx = cnt_plus[TO_W-1:0];
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_status = st_q;
  assign rsp_cycles = cyc_q;

endmodule

// File: tb/tb_multivar_cond_waiter.sv
// Table-driven and randomized bench for multivar_cond_waiter with a
// cycle-indexed reference model of the waiting behaviour.
module tb_multivar_cond_waiter;

  localparam int DW     = 32;
  localparam int TW     = 4;
  localparam int NDIR   = 15;
  localparam int NRND   = 30;
  localparam int NT     = NDIR + NRND;
  localparam int BUDGET = 40;
  localparam int CMAX   = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_sel = '0;
  logic [DW-1:0] wr_data = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [TW-1:0] req_timeout = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic [TW-1:0] rsp_cycles;
  logic [DW-1:0] var_a, var_b, var_c;

  int errors = 0;
  int checks = 0;
  longint m_a = 0, m_b = 0, m_c = 0;

  always #5 clk = ~clk;

  multivar_cond_waiter #(.DATA_W(DW), .TO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_timeout(req_timeout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_cycles(rsp_cycles),
    .var_a(var_a), .var_b(var_b), .var_c(var_c)
  );

  // est: 0=MET 1=TIMEOUT 2=BADOP 3=no response expected; w?c=0 means no write
  typedef struct {
    int a, b, c, op, to;
    int w0c, w0s, w0d, w1c, w1s, w1d;
    int hold;
    int est, ecyc, elat;
  } scen_t;

  scen_t tbl[NT];

  function automatic scen_t mk(int a, int b, int c, int op, int to,
                               int w0c, int w0s, int w0d, int w1c, int w1s, int w1d,
                               int hold, int est, int ecyc, int elat);
    scen_t s;
    s.a = a; s.b = b; s.c = c; s.op = op; s.to = to;
    s.w0c = w0c; s.w0s = w0s; s.w0d = w0d; s.w1c = w1c; s.w1s = w1s; s.w1d = w1d;
    s.hold = hold; s.est = est; s.ecyc = ecyc; s.elat = elat;
    return s;
  endfunction

  function automatic bit pred(int op, longint a, longint b, longint c);
    case (op)
      0: return a > b;
      1: return (a + b) < c;
      2: return (a < b) && (b > c);
      3: return a == c;
      4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // WAIT cycle k sees writes made in cycles < k; a response decided in cycle k
  // is visible k+1 cycles after the accepting edge.
  function automatic scen_t model(scen_t s_in);
    scen_t s = s_in;
    longint a = s.a, b = s.b, c = s.c;
    s.est = 3; s.ecyc = 0; s.elat = 0;
    if (s.op > 4) begin
      s.est = 2; s.elat = 1;
      return s;
    end
    for (int k = 1; k <= BUDGET + 1; k++) begin
      if (pred(s.op, a, b, c)) begin
        s.est = 0; s.ecyc = (k - 1 > CMAX) ? CMAX : k - 1; s.elat = k + 1;
        return s;
      end
      if (s.to != 0 && k == s.to) begin
        s.est = 1; s.ecyc = s.to; s.elat = k + 1;
        return s;
      end
      if (s.w0c == k) begin
        if (s.w0s == 0) a = s.w0d; else if (s.w0s == 1) b = s.w0d; else if (s.w0s == 2) c = s.w0d;
      end
      if (s.w1c == k) begin
        if (s.w1s == 0) a = s.w1d; else if (s.w1s == 1) b = s.w1d; else if (s.w1s == 2) c = s.w1d;
      end
    end
    return s;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(int sel, int data);
    wr_en = 1'b1; wr_sel = sel[1:0]; wr_data = data;
    case (sel)
      0: m_a = data;
      1: m_b = data;
      2: m_c = data;
      default: ;
    endcase
  endtask

  task automatic preload(int a, int b, int c);
    drive_wr(0, a); tick();
    drive_wr(1, b); tick();
    drive_wr(2, c); tick();
    wr_en = 1'b0;
  endtask

  task automatic reset_pulse(string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, " rst req_ready"}, req_ready, 1);
    chk({tag, " rst rsp_valid"}, rsp_valid, 0);
    chk({tag, " rst rsp_status"}, rsp_status, 0);
    chk({tag, " rst rsp_cycles"}, rsp_cycles, 0);
    chk({tag, " rst vars"}, {var_a, var_b, var_c} == '0, 1);
    m_a = 0; m_b = 0; m_c = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk({tag, " post-rst req_ready"}, req_ready, 1);
  endtask

  task automatic run(scen_t s, int idx);
    string tag;
    int lat;
    tag = $sformatf("s%0d", idx);
    preload(s.a, s.b, s.c);
    chk({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_op = s.op[2:0]; req_timeout = s.to[TW-1:0];
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < BUDGET + 2) begin
      wr_en = 1'b0;
      if (s.w0c == lat) drive_wr(s.w0s, s.w0d);
      if (s.w1c == lat) drive_wr(s.w1s, s.w1d);
      tick();
      lat++;
    end
    wr_en = 1'b0;
    if (s.est == 3) chk({tag, " no_rsp"}, rsp_valid, 0);
    else chk({tag, " latency"}, rsp_valid ? lat : -1, s.elat);
    if (rsp_valid) begin
      if (s.est != 3) begin
        chk({tag, " status"}, rsp_status, s.est);
        chk({tag, " cycles"}, rsp_cycles, s.ecyc);
        chk({tag, " req_ready low"}, req_ready, 0);
      end
      for (int h = 0; h < s.hold; h++) begin
        tick();
        chk({tag, " hold valid"}, rsp_valid, 1);
        chk({tag, " hold status"}, rsp_status, s.est);
        chk({tag, " hold cycles"}, rsp_cycles, s.ecyc);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, " idle rsp_valid"}, rsp_valid, 0);
      chk({tag, " idle req_ready"}, req_ready, 1);
    end else begin
      reset_pulse(tag);
    end
    chk({tag, " var_a"}, $signed(var_a), m_a);
    chk({tag, " var_b"}, $signed(var_b), m_b);
    chk({tag, " var_c"}, $signed(var_c), m_c);
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0,  4, 0, 2,  0, 0, 0,  0, 0, 4, 6);
    tbl[1]  = mk(2, 1, 0, 1, 0,  1, 2, 3,  3, 2, 4,  1, 0, 3, 5);
    tbl[2]  = mk(2, 5, 4, 2, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 2);
    tbl[3]  = mk(0, 1, 0, 0, 5,  0, 0, 0,  0, 0, 0,  0, 1, 5, 6);
    tbl[4]  = mk(0, 1, 0, 0, 5,  4, 0, 2,  0, 0, 0,  0, 0, 4, 6);
    tbl[5]  = mk(0, 0, 0, 6, 0,  0, 0, 0,  0, 0, 0,  3, 2, 0, 1);
    tbl[6]  = mk(int'(32'h7FFF_FFFF), 1, int'(32'h8000_0000), 1, 0,
                 0, 0, 0,  0, 0, 0,  0, 3, 0, 0);
    tbl[7]  = mk(5, 0, 5, 3, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 2);
    tbl[8]  = mk(0, 0, 0, 4, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 2);
    tbl[9]  = mk(0, 0, 0, 7, 3,  0, 0, 0,  0, 0, 0,  0, 2, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 20, 0, 2,  0, 0, 0,  0, 0, CMAX, 22);
    tbl[11] = mk(0, 0, 0, 0, CMAX, 0, 0, 0, 0, 0, 0, 0, 1, CMAX, CMAX + 1);
    tbl[12] = mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0,  0, 1, 1, 2);
    tbl[13] = mk(-1, -2, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    tbl[14] = mk(1, 0, 2, 3, 0,  2, 3, 2,  3, 0, 2,  0, 0, 3, 5);
    for (int i = NDIR; i < NT; i++) begin
      scen_t s;
      s = mk(int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
             int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 7)),
             ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, CMAX)),
             int'($urandom_range(0, 8)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 6)) - 3,
             int'($urandom_range(0, 8)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 6)) - 3,
             int'($urandom_range(0, 2)), 0, 0, 0);
      if (s.w1c == s.w0c) s.w1c = 0;
      tbl[i] = model(s);
    end

    #12;
    chk("reset req_ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_status", rsp_status, 0);
    chk("reset rsp_cycles", rsp_cycles, 0);
    chk("reset vars", {var_a, var_b, var_c} == '0, 1);
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int i = 0; i < NT; i++) run(tbl[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/multivar_cond_waiter.md
MULTIVAR_COND_WAITER -- requirements
Module: multivar_cond_waiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each signed variable.
REQ-002 SHALL have parameter TO_W, default 16, meaning width of timeout and cycle counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_en  input  1  variable write strobe.
REQ-006 wr_sel  input  2  write target: 0=a, 1=b, 2=c, 3=ignored.
REQ-007 wr_data  input  DATA_W  signed write value.
REQ-008 req_valid  input  1  wait request present.
REQ-009 req_ready  output  1  block accepts a request.
REQ-010 req_op  input  3  predicate opcode.
REQ-011 req_timeout  input  TO_W  false-cycle limit; 0 = wait forever.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_status  output  2  0=MET, 1=TIMEOUT, 2=BADOP.
REQ-015 rsp_cycles  output  TO_W  count of WAIT cycles in which the predicate was false.
REQ-016 var_a, var_b, var_c  output  DATA_W each  current registered variable values.

Function
REQ-017 SHALL implement states IDLE, WAIT, RESP; req_ready = (state==IDLE); rsp_valid = (state==RESP).
REQ-018 A write with wr_en=1 SHALL update the selected variable at the clock edge; wr_sel=3 SHALL change nothing; writes are accepted in every state.
REQ-019 Predicates SHALL use registered variable values only; a write in cycle N is first visible to evaluation in cycle N+1.
REQ-020 Opcodes: 0 a>b; 1 a+b<c; 2 (a<b)&&(b>c); 3 a==c; 4 always true; 5-7 invalid.
REQ-021 All comparisons SHALL be signed; a+b SHALL be computed in DATA_W+1 bits with no wrap-around.
REQ-022 IDLE: on req_valid&&req_ready, SHALL latch op and timeout, clear the cycle counter, and go to WAIT; an invalid op SHALL go directly to RESP with BADOP and rsp_cycles=0.
REQ-023 WAIT: predicate true SHALL go to RESP with MET; otherwise the counter SHALL increment, saturating at all-ones.
REQ-024 WAIT: if timeout!=0, predicate false, and counter+1==timeout, SHALL go to RESP with TIMEOUT and rsp_cycles=timeout.
REQ-025 Predicate true SHALL take priority over timeout in the same cycle.
REQ-026 Minimum latency: rsp_valid high in the second cycle after acceptance for a predicate already true; first cycle after acceptance for BADOP.
REQ-027 RESP: rsp_status and rsp_cycles SHALL hold stable until rsp_ready; on rsp_ready go to IDLE; the next request can be accepted no earlier than the following cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, clear var_a/b/c, counter, rsp_status, and rsp_cycles to 0, and drive rsp_valid=0 and req_ready=1 after release.
REQ-029 Reset during WAIT or RESP SHALL discard the pending request with no response.

Structure
REQ-030 Package multivar_cond_pkg SHALL hold the opcode enum, status enum, wr_sel constants, and state enum.
REQ-031 The predicate evaluator SHALL be one combinational sub-module, multivar_cond_pred (inputs a, b, c, op; outputs true and op_valid).

Verification
REQ-032 a=0, b=0, op0 accepted; write a=2 during WAIT cycle 4 -> MET, rsp_cycles=4.
REQ-033 a=2, b=1, c=0, op1; write c=3, then c=4 two cycles later -> no response after c=3; MET the cycle after c=4 is visible.
REQ-034 a=2, b=5, c=4 preloaded, op2 -> MET, rsp_cycles=0, rsp_valid in the second cycle after acceptance.
REQ-035 op0 with a=0, b=1, timeout=5 -> TIMEOUT, rsp_cycles=5; repeat with a=2 written so the predicate becomes visible in WAIT cycle 5 -> MET wins.
REQ-036 op6 with rsp_ready low for 3 cycles -> BADOP the cycle after acceptance, outputs stable; IDLE after rsp_ready.
REQ-037 a=0x7FFFFFFF, b=1, c=0x80000000, op1 -> never MET (no wrap-around); rst_n pulsed in WAIT -> all outputs 0 and req_ready=1.
